// File: rtl/planning_move_scheduler.sv
// Turn-based move scheduler for the grid planner: holds robot and obstacle
// positions, arbitrates one move per cycle, and tracks INIT/RUN/GOAL/ERROR.
module planning_move_scheduler #(
    parameter int unsigned CW     = 3,
    parameter int unsigned ROB_X0 = 0,
    parameter int unsigned ROB_Y0 = 0,
    parameter int unsigned OB1_X0 = 3,
    parameter int unsigned OB1_Y0 = 3,
    parameter int unsigned OB2_X0 = 5,
    parameter int unsigned OB2_Y0 = 5,
    parameter int unsigned GOAL_X = 7,
    parameter int unsigned GOAL_Y = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          end_init,
    input  logic [3:0]    req_rob,
    input  logic [3:0]    req_ob1,
    input  logic [3:0]    req_ob2,
    output logic [CW-1:0] rob_x,
    output logic [CW-1:0] rob_y,
    output logic [CW-1:0] ob1_x,
    output logic [CW-1:0] ob1_y,
    output logic [CW-1:0] ob2_x,
    output logic [CW-1:0] ob2_y,
    output logic [2:0]    grant,
    output logic          blocked,
    output logic          rt_rob,
    output logic          rt_ob1,
    output logic          rt_ob2,
    output logic [1:0]    phase,
    output logic          error,
    output logic          done
);

    typedef enum logic [1:0] {
        StInit  = 2'b00,
        StRun   = 2'b01,
        StGoal  = 2'b10,
        StError = 2'b11
    } phase_e;

    localparam logic [CW-1:0] MaxC  = {CW{1'b1}};
    localparam logic [CW-1:0] OneC  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] GoalX = GOAL_X[CW-1:0];
    localparam logic [CW-1:0] GoalY = GOAL_Y[CW-1:0];

    phase_e        state;
    logic          init_ptr;      // 0: ob1 owns the INIT tie-break, 1: ob2
    logic [2:0]    sel;           // one-hot {ob2,ob1,rob} agent serviced this cycle
    logic [3:0]    sel_req;
    logic [CW-1:0] cur_x, cur_y, nx, ny;
    logic          multi_hot, off_grid;
    logic          hit_rob, hit_ob1, hit_ob2;
    logic          collide, occupied, at_goal;
    logic          apply_move, set_blocked, go_error, go_goal;

    assign phase = state;

    // Pick the agent being serviced: INIT arbitration among obstacles, RUN turn owner.
    always_comb begin
        sel = 3'b000;
        case (state)
            StInit: begin
                if (|req_ob1 && |req_ob2) sel = init_ptr ? 3'b100 : 3'b010;
                else if (|req_ob1)        sel = 3'b010;
                else if (|req_ob2)        sel = 3'b100;
            end
            StRun:   sel = {rt_ob2, rt_ob1, rt_rob};
            default: sel = 3'b000;
        endcase
    end

    // Destination of the selected move and the checks that may reject it.
    always_comb begin
        sel_req = 4'b0000;
        cur_x   = '0;
        cur_y   = '0;
        if (sel[0]) begin
            sel_req = req_rob;
            cur_x   = rob_x;
            cur_y   = rob_y;
        end else if (sel[1]) begin
            sel_req = req_ob1;
            cur_x   = ob1_x;
            cur_y   = ob1_y;
        end else if (sel[2]) begin
            sel_req = req_ob2;
            cur_x   = ob2_x;
            cur_y   = ob2_y;
        end

        multi_hot = (sel_req & (sel_req - 4'd1)) != 4'd0;

        nx       = cur_x;
        ny       = cur_y;
        off_grid = 1'b0;
        case (sel_req)
            4'b1000: if (cur_y == MaxC)  off_grid = 1'b1; else ny = cur_y + OneC;
            4'b0100: if (cur_y == '0)    off_grid = 1'b1; else ny = cur_y - OneC;
            4'b0010: if (cur_x == '0)    off_grid = 1'b1; else nx = cur_x - OneC;
            4'b0001: if (cur_x == MaxC)  off_grid = 1'b1; else nx = cur_x + OneC;
            default: ;
        endcase

        hit_rob = (nx == rob_x) && (ny == rob_y);
        hit_ob1 = (nx == ob1_x) && (ny == ob1_y);
        hit_ob2 = (nx == ob2_x) && (ny == ob2_y);

        // During INIT touching the robot is only a blocked move, not a collision.
        collide  = 1'b0;
        occupied = 1'b0;
        if (sel[0]) begin
            collide = hit_ob1 | hit_ob2;
        end else if (sel[1]) begin
            if (state == StRun) begin
                collide  = hit_rob;
                occupied = hit_ob2;
            end else begin
                occupied = hit_rob | hit_ob2;
            end
        end else if (sel[2]) begin
            if (state == StRun) begin
                collide  = hit_rob;
                occupied = hit_ob1;
            end else begin
                occupied = hit_rob | hit_ob1;
            end
        end

        at_goal = sel[0] && (nx == GoalX) && (ny == GoalY);
    end

    // Resolve the move with priority multi-hot > off-grid > collision/occupied > goal.
    always_comb begin
        apply_move  = 1'b0;
        set_blocked = 1'b0;
        go_error    = 1'b0;
        go_goal     = 1'b0;
        if (sel != 3'b000 && sel_req != 4'b0000) begin
            if (multi_hot)      go_error    = 1'b1;
            else if (off_grid)  set_blocked = 1'b1;
            else if (collide)   go_error    = 1'b1;
            else if (occupied)  set_blocked = 1'b1;
            else begin
                apply_move = 1'b1;
                go_goal    = at_goal;
            end
        end
    end

    // Phase FSM, positions and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StInit;
            init_ptr <= 1'b0;
            rob_x    <= ROB_X0[CW-1:0];
            rob_y    <= ROB_Y0[CW-1:0];
            ob1_x    <= OB1_X0[CW-1:0];
            ob1_y    <= OB1_Y0[CW-1:0];
            ob2_x    <= OB2_X0[CW-1:0];
            ob2_y    <= OB2_Y0[CW-1:0];
            grant    <= 3'b000;
            blocked  <= 1'b0;
            rt_rob   <= 1'b0;
            rt_ob1   <= 1'b0;
            rt_ob2   <= 1'b0;
            error    <= 1'b0;
            done     <= 1'b0;
        end else begin
            grant   <= apply_move ? sel : 3'b000;
            blocked <= set_blocked;

            if (apply_move) begin
                if (sel[0]) begin
                    rob_x <= nx;
                    rob_y <= ny;
                end
                if (sel[1]) begin
                    ob1_x <= nx;
                    ob1_y <= ny;
                end
                if (sel[2]) begin
                    ob2_x <= nx;
                    ob2_y <= ny;
                end
            end

            // Tie-break pointer moves away from whichever obstacle was serviced.
            if (state == StInit && sel != 3'b000) init_ptr <= sel[1];

            case (state)
                StInit: begin
                    if (go_error) begin
                        state <= StError;
                        error <= 1'b1;
                    end else if (end_init) begin
                        state  <= StRun;
                        rt_rob <= 1'b1;
                    end
                end
                StRun: begin
                    if (go_error || go_goal) begin
                        state  <= go_error ? StError : StGoal;
                        error  <= go_error;
                        done   <= go_goal;
                        rt_rob <= 1'b0;
                        rt_ob1 <= 1'b0;
                        rt_ob2 <= 1'b0;
                    end else begin
                        rt_rob <= rt_ob2;
                        rt_ob1 <= rt_rob;
                        rt_ob2 <= rt_ob1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_planning_move_scheduler.sv
// Scoreboard bench for planning_move_scheduler: expected snapshots are pushed
// as stimulus is driven and popped when the edge's outputs are sampled.
module tb_planning_move_scheduler;

    typedef struct packed {
        logic [2:0] rx, ry, o1x, o1y, o2x, o2y;
        logic [2:0] grant;
        logic       blocked;
        logic [2:0] rt;       // {ob2, ob1, rob}
        logic [1:0] phase;
        logic       error;
        logic       done;
    } snap_t;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n = 1'b1;
    logic       end_init = 1'b0;
    logic [3:0] req_rob = 4'b0, req_ob1 = 4'b0, req_ob2 = 4'b0;
    logic [2:0] rob_x, rob_y, ob1_x, ob1_y, ob2_x, ob2_y, grant;
    logic       blocked, rt_rob, rt_ob1, rt_ob2, error, done;
    logic [1:0] phase;

    snap_t e, exp_v, got;
    snap_t sb[$];
    int    checks = 0;
    int    errors = 0;

    planning_move_scheduler dut (
        .clk(clk), .rst_n(rst_n), .end_init(end_init),
        .req_rob(req_rob), .req_ob1(req_ob1), .req_ob2(req_ob2),
        .rob_x(rob_x), .rob_y(rob_y), .ob1_x(ob1_x), .ob1_y(ob1_y),
        .ob2_x(ob2_x), .ob2_y(ob2_y), .grant(grant), .blocked(blocked),
        .rt_rob(rt_rob), .rt_ob1(rt_ob1), .rt_ob2(rt_ob2),
        .phase(phase), .error(error), .done(done)
    );

    always #5 if (clk_en) clk = ~clk;

    function automatic snap_t snap();
        snap_t s;
        s.rx = rob_x;  s.ry = rob_y;
        s.o1x = ob1_x; s.o1y = ob1_y;
        s.o2x = ob2_x; s.o2y = ob2_y;
        s.grant = grant; s.blocked = blocked;
        s.rt = {rt_ob2, rt_ob1, rt_rob};
        s.phase = phase; s.error = error; s.done = done;
        return s;
    endfunction

    function automatic snap_t reset_exp();
        snap_t s;
        s = '0;
        s.o1x = 3'd3; s.o1y = 3'd3;
        s.o2x = 3'd5; s.o2y = 3'd5;
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        end_init = 1'b0; req_rob = 4'b0; req_ob1 = 4'b0; req_ob2 = 4'b0;
        @(negedge clk);
        rst_n = 1'b1;
        e = reset_exp();
    endtask

    task automatic test_reset();
        #7 rst_n = 1'b0;
        #3;
        got = snap();
        checks++;
        if (got !== reset_exp()) begin
            errors++;
            $display("FAIL reset_no_clock got %h expected %h", got, reset_exp());
        end
        clk_en = 1'b1;
        do_reset();
    endtask

    task automatic test_init_arb();
        snap_t tbl [4];
        do_reset();
        req_ob1 = 4'b1000; req_ob2 = 4'b0010; req_rob = 4'b0001;
        tbl[0] = e; tbl[0].o1y = 3'd4; tbl[0].grant = 3'b010;
        tbl[1] = tbl[0]; tbl[1].o2x = 3'd4; tbl[1].grant = 3'b100;
        tbl[2] = tbl[1]; tbl[2].o1y = 3'd5; tbl[2].grant = 3'b010;
        // ob2 moving left from (4,5) lands on ob1 at (3,5)
        tbl[3] = tbl[2]; tbl[3].grant = 3'b000; tbl[3].blocked = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sb.push_back(tbl[k]);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            got = snap();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL init_arb edge %0d got %h expected %h", k + 1, got, exp_v);
            end
        end
    endtask

    task automatic test_run_boundary();
        snap_t tbl [5];
        logic [3:0] rr [5];
        logic [3:0] r2 [5];
        logic       ei [5];
        do_reset();
        // edge 1: end_init with a concurrent ob1 move that is still applied
        ei[0] = 1'b1; rr[0] = 4'b0;    r2[0] = 4'b0;
        tbl[0] = e; tbl[0].o1y = 3'd4; tbl[0].grant = 3'b010;
        tbl[0].phase = 2'b01; tbl[0].rt = 3'b001;
        // edge 2: robot turn, down from y=0 is off-grid
        ei[1] = 1'b0; rr[1] = 4'b0100; r2[1] = 4'b0;
        tbl[1] = tbl[0]; tbl[1].grant = 3'b000; tbl[1].blocked = 1'b1; tbl[1].rt = 3'b010;
        // edge 3: ob1 turn, robot request ignored
        ei[2] = 1'b1; rr[2] = 4'b0100; r2[2] = 4'b1000;
        tbl[2] = tbl[1]; tbl[2].blocked = 1'b0; tbl[2].rt = 3'b100;
        // edge 4: ob2 turn, up to (5,6)
        ei[3] = 1'b0; rr[3] = 4'b0;    r2[3] = 4'b1000;
        tbl[3] = tbl[2]; tbl[3].o2y = 3'd6; tbl[3].grant = 3'b100; tbl[3].rt = 3'b001;
        // edge 5: robot idle, turn still rotates
        ei[4] = 1'b0; rr[4] = 4'b0;    r2[4] = 4'b1000;
        tbl[4] = tbl[3]; tbl[4].grant = 3'b000; tbl[4].rt = 3'b010;
        req_ob1 = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            end_init = ei[k]; req_rob = rr[k]; req_ob2 = r2[k];
            if (k > 0) req_ob1 = 4'b0;
            sb.push_back(tbl[k]);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            got = snap();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL run_boundary edge %0d got %h expected %h", k + 1, got, exp_v);
            end
        end
    endtask

    task automatic test_collision();
        logic [3:0] mv [6];
        do_reset();
        mv = '{4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0010};
        req_rob = 4'b1000;  // ignored throughout INIT
        for (int k = 0; k < 6; k++) begin
            req_ob1 = mv[k];
            e.grant = 3'b010; e.blocked = 1'b0;
            if (k < 3) e.o1y = e.o1y - 3'd1;
            else if (k < 5) e.o1x = e.o1x - 3'd1;
            else begin e.grant = 3'b000; e.blocked = 1'b1; end  // (1,0)->(0,0) robot
            sb.push_back(e);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            got = snap();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL collision_init edge %0d got %h expected %h", k + 1, got, exp_v);
            end
        end
        for (int k = 0; k < 5; k++) begin
            req_ob1 = 4'b0; end_init = 1'b0; req_ob2 = 4'b0;
            e.grant = 3'b000; e.blocked = 1'b0;
            if (k == 0) begin
                end_init = 1'b1; e.phase = 2'b01; e.rt = 3'b001;
            end else if (k == 1) begin
                req_rob = 4'b0001; e.phase = 2'b11; e.error = 1'b1; e.rt = 3'b000;
            end else begin
                req_rob = 4'b1000; req_ob1 = 4'b1000; req_ob2 = 4'b0100;
            end
            sb.push_back(e);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            got = snap();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL collision_run edge %0d got %h expected %h", k + 1, got, exp_v);
            end
        end
    endtask

    task automatic test_goal();
        int turn, moves;
        do_reset();
        turn = 0; moves = 0;
        for (int k = 0; k <= 43; k++) begin
            end_init = (k == 0);
            req_rob = (moves < 7) ? 4'b0001 : 4'b1000;
            e.grant = 3'b000;
            if (k == 0) begin
                e.phase = 2'b01; e.rt = 3'b001;
            end else if (e.phase == 2'b01) begin
                if (turn == 0) begin
                    if (moves < 7) e.rx = e.rx + 3'd1;
                    else e.ry = e.ry + 3'd1;
                    moves++;
                    e.grant = 3'b001;
                    if (moves == 14) begin e.phase = 2'b10; e.done = 1'b1; end
                end
                turn = (turn + 1) % 3;
                e.rt = (e.phase == 2'b01) ? (3'b001 << turn) : 3'b000;
            end
            sb.push_back(e);
            @(posedge clk); #1;
            exp_v = sb.pop_front();
            got = snap();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL goal edge %0d got %h expected %h", k, got, exp_v);
            end
        end
    endtask

    task automatic test_multihot();
        do_reset();
        end_init = 1'b1;
        @(posedge clk); #1;
        end_init = 1'b0;
        req_rob = 4'b1010;
        e.phase = 2'b11; e.error = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        exp_v = sb.pop_front();
        got = snap();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL multihot got %h expected %h", got, exp_v);
        end
    endtask

    task automatic test_midrun_reset();
        do_reset();
        end_init = 1'b1;
        @(posedge clk); #1;
        end_init = 1'b0;
        req_rob = 4'b0001; req_ob1 = 4'b1000;
        e.rx = 3'd1; e.o1y = 3'd4; e.phase = 2'b01; e.rt = 3'b100; e.grant = 3'b010;
        sb.push_back(e);
        repeat (2) @(posedge clk);
        #1;
        exp_v = sb.pop_front();
        got = snap();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL midrun_before got %h expected %h", got, exp_v);
        end
        #2 rst_n = 1'b0;
        #1;
        got = snap();
        checks++;
        if (got !== reset_exp()) begin
            errors++;
            $display("FAIL midrun_reset got %h expected %h", got, reset_exp());
        end
        @(negedge clk);
        rst_n = 1'b1;
        req_rob = 4'b0; req_ob1 = 4'b0;
    endtask

    initial begin
        test_reset();
        test_init_arb();
        test_run_boundary();
        test_collision();
        test_goal();
        test_multihot();
        test_midrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
